spi_frame_tx: RTL and testbench
===============================

# spi_frame_tx

SPI frame initiator: serialises one 16-bit frame (8-bit register address in the high byte, 8-bit value in the low byte) per valid/ready handshake onto CS/CLK/MOSI. It captures MISO into a 16-bit receive word on the same bit edges. It sits on the XTALCLK fabric side and drives the register-bank slave and the downstream ADC/DAC chip-select path. The bit order and edge convention are those of the register-bank slave: CLK idles low, the slave samples on falling edges, and the slave latches on CS rising.

## Interface
- MSB, 16: frame width in bits; fixed at 16; address = bits 15:8, value = bits 7:0.
- CLKDIV, 4: XTALCLK cycles per CLK_O half period; legal range 1..255.

Ports:
- XTALCLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- tx_valid  in  1  request to send a frame.
- tx_ready  out  1  block is idle and accepts a frame this cycle.
- tx_addr  in  8  register address; sampled at accept.
- tx_data  in  8  register value; sampled at accept.
- CS_O  out  1  chip select, active-low.
- CLK_O  out  1  serial clock, idle low.
- MOSI_O  out  1  serial data out, MSB first.
- MISO_I  in  1  serial data in.
- rx_data  out  16  last received frame.
- rx_valid  out  1  one-cycle pulse when rx_data updates.

## Operation
- Accept occurs when tx_valid && tx_ready. At accept, {tx_addr, tx_data} is copied into the tx shift register; tx_ready drops the next cycle.
- The tick divider counts 0..CLKDIV-1 and produces a one-cycle tick on wrap. It restarts at 0 on accept.
- IDLE:
  - CS_O=1, CLK_O=0, tx_ready=1.
  - On accept -> SETUP.
- SETUP:
  - CS_O=0, MOSI_O=bit15.
  - After one half period -> SHIFT.
- SHIFT:
  - CLK_O toggles on each tick.
  - On each rising CLK_O edge, MOSI_O presents the current bit, starting at bit15.
  - On each falling CLK_O edge, MISO_I is shifted into the rx shift register and the bit counter increments.
  - After the 16th falling edge -> HOLD.
- HOLD:
  - CLK_O=0, CS_O=0 for one half period.
  - Then CS_O=1, rx_data <= rx shift register, rx_valid pulses for one cycle -> GAP.
- GAP:
  - CS_O=1 for one half period, guaranteeing a minimum CS-high time for the slave latch.
  - Then -> IDLE.
- tx_valid is ignored while tx_ready=0. tx_addr/tx_data may change freely after accept.
- A tx_valid held high produces back-to-back frames separated only by GAP plus the one IDLE accept cycle.
- Exactly 16 CLK_O falling edges occur per CS_O low window. No partial frame is ever emitted, except on reset.

## Timing
- Let accept be at edge k and D=CLKDIV.
- CS_O falls at k+1.
- CLK_O rising edges occur at k+1+D+2Di and falling edges at k+1+2D+2Di, for i=0..15.
- Last falling edge at k+1+32D; CS_O rises and rx_valid=1 at k+1+33D.
- tx_ready rises at k+1+34D; frame period under continuous tx_valid = 34D+1 cycles.
- MOSI_O is stable for 2D cycles around each falling edge: set up D cycles before it, held D cycles after it.
- Reset values: CS_O=1, CLK_O=0, MOSI_O=0, tx_ready=0 while RST=1 and 1 from the first cycle after; rx_data=0, rx_valid=0, state IDLE, counters 0.
- RST asserted mid-frame:
  - The next edge forces the reset values.
  - CS_O rises without a complete 16-bit frame.
  - rx_data is cleared and no rx_valid is issued.
  - Because CS_O rises, the slave latches whatever it has shifted in, possibly a truncated frame. Firmware must re-send the affected register after reset.
- RST simultaneous with accept: reset wins; the frame is dropped.

## Structure
- Shared package spi_pkg:
  - FRAME_W=16, ADDR_W=8, DATA_W=8.
  - State enum IDLE/SETUP/SHIFT/HOLD/GAP.
  - Register address constants REG_LED=7 and REG_MUX=8, shared with the register bank.
- One sub-module: spi_tick_gen, the CLKDIV half-period divider with synchronous restart and a tick output.
- Top level holds the FSM, the 4-bit bit counter, and the tx/rx shift registers.

## Test plan
- Reset: hold RST for 3 cycles -> CS_O=1, CLK_O=0, MOSI_O=0, tx_ready=0 during reset, tx_ready=1 on the first cycle after.
- Single frame, D=4, addr 0x07, data 0xA5 -> 16 falling edges within CS low; MOSI sampled at the falls = 0x07A5; CS_O low for exactly 132 cycles; tx_ready returns at accept+137.
- Loopback MISO_I=MOSI_O, addr 0x08, data 0x3C -> rx_data=0x083C with a single rx_valid pulse coincident with CS_O rising.
- tx_valid held high for 3 frames (0x0701, 0x0702, 0x0703), D=1 -> three CS windows each with CS_O high ≥ 1 cycle between them, frame period 35 cycles, correct order.
- RST pulsed after the 8th falling edge -> CS_O=1 and CLK_O=0 on the next edge, no rx_valid, rx_data=0; a following frame 0x0755 transmits correctly.
- tx_valid toggled with changing tx_addr/tx_data while busy -> those requests are ignored and the in-flight frame bits are unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: frame geometry, FSM state encodings and register addresses shared with the register bank
package spi_pkg;
  localparam int FRAME_W = 16;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t SETUP = 3'd1;
  localparam state_t SHIFT = 3'd2;
  localparam state_t HOLD = 3'd3;
  localparam state_t GAP = 3'd4;
  localparam logic [ADDR_W-1:0] REG_LED = 8'd7;
  localparam logic [ADDR_W-1:0] REG_MUX = 8'd8;
endpackage

// File: rtl/spi_frame_tx_if.sv
// spi_frame_tx_if: frame request handshake and receive-word return path
interface spi_frame_tx_if;
  import spi_pkg::*;
  logic tx_valid;
  logic tx_ready;
  logic [ADDR_W-1:0] tx_addr;
  logic [DATA_W-1:0] tx_data;
  logic [FRAME_W-1:0] rx_data;
  logic rx_valid;
  modport master(output tx_valid, tx_addr, tx_data, input tx_ready, rx_data, rx_valid);
  modport slave(input tx_valid, tx_addr, tx_data, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: half-period divider, one-cycle tick every DIV cycles, restartable
module spi_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  logic [7:0] cnt_q, cnt_d;
  assign tick = cnt_q == 8'(DIV - 1);
  always_comb cnt_d = (restart || tick) ? '0 : cnt_q + 8'd1;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: serialises one addr/value frame per handshake onto CS/CLK/MOSI, capturing MISO
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic           XTALCLK,
  input  logic           RST,
  spi_frame_tx_if.slave  bus,
  output logic           CS_O,
  output logic           CLK_O,
  output logic           MOSI_O,
  input  logic           MISO_I
);
  state_t state_q, state_d;
  logic cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d, rx_valid_q, rx_valid_d, tick, accept;
  logic [FRAME_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic [3:0] bit_q, bit_d;
  assign bus.tx_ready = state_q == IDLE && !RST;
  assign accept = bus.tx_valid && bus.tx_ready;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign CS_O = cs_q;
  assign CLK_O = sck_q;
  assign MOSI_O = mosi_q;
  spi_tick_gen #(.DIV(CLKDIV)) u_tick (.clk(XTALCLK), .rst(RST), .restart(accept), .tick(tick));
  // MOSI moves only on rising CLK so it is stable a full half period either side of the slave's falling-edge sample
  always_comb begin
    state_d = state_q;
    cs_d = cs_q;
    sck_d = sck_q;
    mosi_d = mosi_q;
    tx_d = tx_q;
    rx_d = rx_q;
    bit_d = bit_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        cs_d = 1'b0;
        tx_d = {bus.tx_addr, bus.tx_data};
        mosi_d = bus.tx_addr[ADDR_W-1];
        bit_d = '0;
      end
      SETUP: if (tick) begin
        state_d = SHIFT;
        sck_d = 1'b1;
        mosi_d = tx_q[FRAME_W-1];
      end
      SHIFT: if (tick && sck_q) begin
        sck_d = 1'b0;
        tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        rx_d = {rx_q[FRAME_W-2:0], MISO_I};
        bit_d = bit_q + 4'd1;
        state_d = bit_q == 4'd15 ? HOLD : SHIFT;
      end else if (tick) begin
        sck_d = 1'b1;
        mosi_d = tx_q[FRAME_W-1];
      end
      HOLD: if (tick) begin
        state_d = GAP;
        cs_d = 1'b1;
        mosi_d = 1'b0;
        rx_data_d = rx_q;
        rx_valid_d = 1'b1;
      end
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge XTALCLK) begin
    if (RST) begin
      state_q <= IDLE;
      cs_q <= 1'b1;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      bit_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q <= cs_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      bit_q <= bit_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end
endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: directed checks of spi_frame_tx with CLKDIV=4 and CLKDIV=1 instances
module tb_spi_frame_tx;
  import spi_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errs = 0;
  int checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  spi_frame_tx_if if4();
  spi_frame_tx_if if1();
  logic cs4, sck4, mosi4, miso4, cs1, sck1, mosi1;
  logic loop4 = 1'b0;
  assign miso4 = loop4 & mosi4;
  spi_frame_tx #(.CLKDIV(4)) dut4 (.XTALCLK(clk), .RST(rst), .bus(if4.slave), .CS_O(cs4), .CLK_O(sck4), .MOSI_O(mosi4), .MISO_I(miso4));
  spi_frame_tx #(.CLKDIV(1)) dut1 (.XTALCLK(clk), .RST(rst), .bus(if1.slave), .CS_O(cs1), .CLK_O(sck1), .MOSI_O(mosi1), .MISO_I(1'b0));
  task automatic frame4(input logic [7:0] a, input logic [7:0] d, input bit junk, output logic [15:0] w,
                        output int falls, output int bad_falls, output int cs_low, output int rdy_lat,
                        output int rxv_n, output int rxv_ok);
    logic pc, pcs;
    int k;
    w = '0; falls = 0; bad_falls = 0; cs_low = 0; rdy_lat = -1; rxv_n = 0; rxv_ok = 0;
    @(negedge clk);
    if4.tx_valid = 1'b1; if4.tx_addr = a; if4.tx_data = d;
    @(negedge clk);
    k = cyc;
    if4.tx_valid = 1'b0;
    check("ready_drop", 32'(if4.tx_ready), 0);
    pc = 1'b0; pcs = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!cs4) cs_low++;
      if (pc && !sck4) begin
        falls++;
        if (cs4) bad_falls++;
        w = {w[14:0], mosi4};
      end
      if (if4.rx_valid) begin
        rxv_n++;
        rxv_ok = int'(cs4 && !pcs);
      end
      if (if4.tx_ready) begin
        rdy_lat = cyc + 1 - k;
        break;
      end
      pc = sck4; pcs = cs4;
      @(negedge clk);
      if (junk) begin
        if4.tx_valid = ~if4.tx_valid;
        if4.tx_addr = 8'($urandom);
        if4.tx_data = 8'($urandom);
      end
    end
    if4.tx_valid = 1'b0;
  endtask
  logic [15:0] w;
  int falls, bad, csl, rdy, rxn, rxok, n, nacc, nw, gi;
  logic pc, pcs;
  int acc[3];
  logic [15:0] words[3];
  int gap[2];
  int hi;
  logic [7:0] dv[3];
  initial begin
    dv[0] = 8'h01; dv[1] = 8'h02; dv[2] = 8'h03;
    if4.tx_valid = 0; if4.tx_addr = 0; if4.tx_data = 0;
    if1.tx_valid = 0; if1.tx_addr = 0; if1.tx_data = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst_cs", 32'(cs4), 1);
      check("rst_clk", 32'(sck4), 0);
      check("rst_mosi", 32'(mosi4), 0);
      check("rst_ready", 32'(if4.tx_ready), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(if4.tx_ready), 1);
    check("post_rst_rxdata", 32'(if4.rx_data), 0);
    check("post_rst_rxvalid", 32'(if4.rx_valid), 0);
    frame4(REG_LED, 8'hA5, 1'b0, w, falls, bad, csl, rdy, rxn, rxok);
    check("f1_mosi", 32'(w), 32'h07A5);
    check("f1_falls", falls, 16);
    check("f1_falls_cs_high", bad, 0);
    check("f1_cs_low", csl, 132);
    check("f1_ready_lat", rdy, 137);
    check("f1_rxv_count", rxn, 1);
    frame4(8'h12, 8'h34, 1'b1, w, falls, bad, csl, rdy, rxn, rxok);
    check("busy_mosi", 32'(w), 32'h1234);
    check("busy_falls", falls, 16);
    check("busy_cs_low", csl, 132);
    check("busy_ready_lat", rdy, 137);
    check("busy_rxdata", 32'(if4.rx_data), 0);
    loop4 = 1'b1;
    frame4(REG_MUX, 8'h3C, 1'b0, w, falls, bad, csl, rdy, rxn, rxok);
    loop4 = 1'b0;
    check("lb_mosi", 32'(w), 32'h083C);
    check("lb_rxdata", 32'(if4.rx_data), 32'h083C);
    check("lb_rxv_count", rxn, 1);
    check("lb_rxv_at_cs_rise", rxok, 1);
    @(negedge clk);
    if4.tx_valid = 1'b1; if4.tx_addr = 8'h07; if4.tx_data = 8'h55;
    @(negedge clk);
    if4.tx_valid = 1'b0;
    pc = 1'b0; n = 0;
    for (int i = 0; i < 400; i++) begin
      if (pc && !sck4) n++;
      if (n == 8) break;
      pc = sck4;
      @(negedge clk);
    end
    check("mid_falls", n, 8);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cs", 32'(cs4), 1);
    check("mid_rst_clk", 32'(sck4), 0);
    check("mid_rst_mosi", 32'(mosi4), 0);
    check("mid_rst_rxdata", 32'(if4.rx_data), 0);
    check("mid_rst_rxvalid", 32'(if4.rx_valid), 0);
    rst = 1'b0;
    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (if4.rx_valid || !cs4) n++;
    end
    check("mid_rst_no_resume", n, 0);
    frame4(8'h07, 8'h55, 1'b0, w, falls, bad, csl, rdy, rxn, rxok);
    check("after_rst_mosi", 32'(w), 32'h0755);
    check("after_rst_falls", falls, 16);
    check("after_rst_ready_lat", rdy, 137);
    @(negedge clk);
    if1.tx_valid = 1'b1; if1.tx_addr = 8'h07; if1.tx_data = dv[0];
    pc = 1'b0; pcs = 1'b1; w = '0; nacc = 0; nw = 0; gi = 0; hi = 0;
    for (int i = 0; i < 300; i++) begin
      if (pc && !sck1) w = {w[14:0], mosi1};
      if (!pcs && cs1) begin
        if (nw < 3) words[nw] = w;
        nw++;
        hi = 0;
      end
      if (cs1) hi++;
      if (pcs && !cs1 && nw > 0 && gi < 2) begin
        gap[gi] = hi;
        gi++;
      end
      if (if1.tx_valid && if1.tx_ready && nacc < 3) begin
        acc[nacc] = cyc + 1;
        nacc++;
      end
      if (nw == 3 && if1.tx_ready) break;
      pc = sck1; pcs = cs1;
      @(negedge clk);
      if (nacc == 3) if1.tx_valid = 1'b0;
      else if1.tx_data = dv[nacc];
    end
    if1.tx_valid = 1'b0;
    check("b2b_accepts", nacc, 3);
    check("b2b_windows", nw, 3);
    check("b2b_period_1", acc[1] - acc[0], 35);
    check("b2b_period_2", acc[2] - acc[1], 35);
    check("b2b_word_0", 32'(words[0]), 32'h0701);
    check("b2b_word_1", 32'(words[1]), 32'h0702);
    check("b2b_word_2", 32'(words[2]), 32'h0703);
    check("b2b_gap_1", gap[0], 2);
    check("b2b_gap_2", gap[1], 2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
